// File: rtl/rf_pkg.sv
// Shared definitions for the register file with busy scoreboard.
//   RF_XLEN / RF_NREGS : default data width and register count
//   rf_aw()            : index width for a given register count
//   rf_idx_t           : register index at the default register count
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  // Index width; a single-register file still needs one index bit.
  function automatic int rf_aw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int RF_AW = rf_aw(RF_NREGS);

  typedef logic [RF_AW-1:0] rf_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for the issue stage.
//   clk, rst      : clock, synchronous active-high reset
//   write_en_i    : writeback valid, releases write_num_i
//   write_num_i   : writeback index
//   rsv_en_i      : reservation request for rsv_num_i
//   rsv_num_i     : destination index to reserve
//   flush_i       : clears every busy bit
//   busy_o        : registered busy vector (masking is done by the reader)
//   rsv_ok_o      : reservation granted this cycle (combinational)
//   busy_cnt_o    : registered number of busy registers
//   wb_stray_o    : one-cycle pulse after a writeback to a non-busy register
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS    = RF_NREGS,
  parameter  int ZERO_REG = 1,
  localparam int AW       = rf_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en_i,
  input  logic [AW-1:0]    write_num_i,
  input  logic             rsv_en_i,
  input  logic [AW-1:0]    rsv_num_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] busy_o,
  output logic             rsv_ok_o,
  output logic [AW:0]      busy_cnt_o,
  output logic             wb_stray_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             stray_q, stray_d;

  logic wr_zero, rsv_zero, wr_rel, wr_match, rsv_set, inc, dec;

  always_comb begin
    wr_zero  = (ZERO_REG != 0) && (write_num_i == '0);
    rsv_zero = (ZERO_REG != 0) && (rsv_num_i == '0);
    wr_rel   = write_en_i && !wr_zero;
    wr_match = write_en_i && (write_num_i == rsv_num_i);

    // A busy destination is still grantable when its writeback lands now.
    rsv_ok_o = rsv_en_i && !flush_i &&
               (rsv_zero || !busy_q[rsv_num_i] || wr_match);
    // The zero register is granted but never tracked.
    rsv_set  = rsv_ok_o && !rsv_zero;

    // Release first, then reserve: same-register overlap ends up set.
    busy_d = busy_q;
    if (wr_rel)  busy_d[write_num_i] = 1'b0;
    if (rsv_set) busy_d[rsv_num_i]   = 1'b1;
    if (flush_i) busy_d = '0;

    // Incremental popcount; a reserve+release of one register nets zero.
    inc   = rsv_set && !busy_q[rsv_num_i];
    dec   = wr_rel && busy_q[write_num_i] &&
            !(rsv_set && (rsv_num_i == write_num_i));
    cnt_d = flush_i ? '0 : cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};

    stray_d = wr_rel && !flush_i && !busy_q[write_num_i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;
  assign wb_stray_o = stray_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with write bypass, optional hardwired-zero
// register and a busy scoreboard for issue.
//   clk, rst   : clock, synchronous active-high reset (clears data and busy)
//   read_num   : NREAD flattened read indices, port i at [i*AW +: AW]
//   read_res   : NREAD flattened read data, combinational
//   read_busy  : per read port, register holds no valid data yet
//   write_en/write_num/write_res : writeback port, also releases busy
//   rsv_en/rsv_num : issue reservation request
//   rsv_ok     : reservation granted this cycle
//   flush      : clears every busy bit
//   busy_cnt   : registered number of busy registers
//   wb_stray   : one-cycle pulse after a writeback to a non-busy register
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int XLEN     = RF_XLEN,
  parameter  int NREGS    = RF_NREGS,
  parameter  int NREAD    = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = rf_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   read_num,
  output logic [NREAD*XLEN-1:0] read_res,
  output logic [NREAD-1:0]      read_busy,
  input  logic                  write_en,
  input  logic [AW-1:0]         write_num,
  input  logic [XLEN-1:0]       write_res,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_num,
  output logic                  rsv_ok,
  input  logic                  flush,
  output logic [AW:0]           busy_cnt,
  output logic                  wb_stray
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0]           busy;
  logic                       we_eff;

  // Writes to the hardwired-zero register are dropped; flush never blocks.
  assign we_eff = write_en && !((ZERO_REG != 0) && (write_num == '0));

  always_ff @(posedge clk) begin
    if (rst)         regs_q            <= '0;
    else if (we_eff) regs_q[write_num] <= write_res;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] idx;
    logic          hit, zero;

    assign idx  = read_num[i*AW +: AW];
    assign hit  = (BYPASS != 0) && write_en && (write_num == idx);
    assign zero = (ZERO_REG != 0) && (idx == '0);

    // Zero check wins over bypass so index 0 reads 0 even mid-write.
    assign read_res[i*XLEN +: XLEN] = zero ? '0 :
                                      hit  ? write_res : regs_q[idx];
    // A write landing this cycle makes the data valid for the reader.
    assign read_busy[i] = busy[idx] && !hit && !zero;
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .write_en_i  (write_en),
    .write_num_i (write_num),
    .rsv_en_i    (rsv_en),
    .rsv_num_i   (rsv_num),
    .flush_i     (flush),
    .busy_o      (busy),
    .rsv_ok_o    (rsv_ok),
    .busy_cnt_o  (busy_cnt),
    .wb_stray_o  (wb_stray)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum int { K_RES0, K_RES1, K_BUSY0, K_BUSY1, K_OK, K_CNT, K_STRAY } kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*AW-1:0] read_num;
  logic [2*XLEN-1:0] read_res;
  logic [1:0]      read_busy;
  logic            write_en;
  logic [AW-1:0]   write_num;
  logic [XLEN-1:0] write_res;
  logic            rsv_en;
  logic [AW-1:0]   rsv_num;
  logic            rsv_ok;
  logic            flush;
  logic [AW:0]     busy_cnt;
  logic            wb_stray;

  int checks   = 0;
  int failures = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk       (clk),
    .rst       (rst),
    .read_num  (read_num),
    .read_res  (read_res),
    .read_busy (read_busy),
    .write_en  (write_en),
    .write_num (write_num),
    .write_res (write_res),
    .rsv_en    (rsv_en),
    .rsv_num   (rsv_num),
    .rsv_ok    (rsv_ok),
    .flush     (flush),
    .busy_cnt  (busy_cnt),
    .wb_stray  (wb_stray)
  );

  function automatic logic [31:0] actual(input kind_t k);
    case (k)
      K_RES0:  return read_res[31:0];
      K_RES1:  return read_res[63:32];
      K_BUSY0: return {31'd0, read_busy[0]};
      K_BUSY1: return {31'd0, read_busy[1]};
      K_OK:    return {31'd0, rsv_ok};
      K_CNT:   return {26'd0, busy_cnt};
      default: return {31'd0, wb_stray};
    endcase
  endfunction

  // Monitor: every expectation queued for this cycle is checked mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.val) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.val);
      end
    end
  end

  task automatic expect_v(input kind_t k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0; rsv_en = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic rd(input int a, input int b);
    read_num = {b[AW-1:0], a[AW-1:0]};
  endtask

  task automatic wr(input int n, input logic [31:0] d);
    write_en = 1'b1; write_num = n[AW-1:0]; write_res = d;
  endtask

  task automatic rsv(input int n);
    rsv_en = 1'b1; rsv_num = n[AW-1:0];
  endtask

  initial begin
    rst = 1'b1; read_num = '0; write_en = 1'b0; write_num = '0;
    write_res = '0; rsv_en = 1'b0; rsv_num = '0; flush = 1'b0;
    next();
    idle();

    // Reset state across all indices.
    expect_v(K_CNT, 0, "reset_cnt");
    expect_v(K_STRAY, 0, "reset_stray");
    for (int i = 0; i < 32; i++) begin
      rd(i, 31 - i);
      expect_v(K_RES0, 0, "reset_res0");
      expect_v(K_RES1, 0, "reset_res1");
      expect_v(K_BUSY0, 0, "reset_busy0");
      expect_v(K_BUSY1, 0, "reset_busy1");
      next();
    end

    // Write then read back on port 1.
    for (int i = 1; i < 32; i++) begin
      wr(i, i); next();
      idle(); rd(0, i);
      expect_v(K_RES1, i, "wr_readback");
      next();
    end
    wr(0, 32'hDEADBEEF); rd(0, 0);
    expect_v(K_RES0, 0, "zero_reg_bypass");
    next();
    idle();
    expect_v(K_RES0, 0, "zero_reg_after");
    expect_v(K_RES1, 0, "zero_reg_after_p1");
    next();

    // Bypass.
    wr(5, 7); next();
    wr(5, 9); rd(5, 5);
    expect_v(K_RES0, 9, "bypass_p0");
    expect_v(K_RES1, 9, "bypass_p1");
    next();
    idle();
    expect_v(K_RES0, 9, "bypass_after");
    next();

    // Scoreboard hazard on register 3.
    rd(3, 0); rsv(3);
    expect_v(K_OK, 1, "rsv3_ok");
    expect_v(K_CNT, 0, "rsv3_cnt_before");
    expect_v(K_BUSY0, 0, "rsv3_busy_before");
    next();
    rsv(3);
    expect_v(K_OK, 0, "rsv3_waw_denied");
    expect_v(K_CNT, 1, "rsv3_cnt");
    expect_v(K_BUSY0, 1, "rsv3_busy");
    next();
    rsv(3); wr(3, 32'h33);
    expect_v(K_OK, 1, "rsv3_with_wb_ok");
    expect_v(K_CNT, 1, "rsv3_denied_cnt");
    expect_v(K_BUSY0, 0, "rsv3_bypass_busy");
    next();
    rsv_en = 1'b0; wr(3, 32'h34);
    expect_v(K_CNT, 1, "rsv3_newowner_cnt");
    next();
    idle();
    expect_v(K_CNT, 0, "wb3_release_cnt");
    expect_v(K_BUSY0, 0, "wb3_release_busy");
    expect_v(K_STRAY, 0, "wb3_not_stray");
    expect_v(K_RES0, 32'h34, "wb3_data");
    rsv(0);
    expect_v(K_OK, 1, "rsv0_ok");
    next();
    idle();
    expect_v(K_CNT, 0, "rsv0_no_state");
    expect_v(K_BUSY1, 0, "rsv0_not_busy");
    next();

    // Flush and stray writeback.
    rsv(4); expect_v(K_OK, 1, "rsv4_ok"); next();
    rsv(6); expect_v(K_OK, 1, "rsv6_ok"); next();
    rsv(8); expect_v(K_OK, 1, "rsv8_ok"); next();
    rsv(10); flush = 1'b1; wr(4, 32'h11);
    expect_v(K_OK, 0, "flush_denies_rsv");
    expect_v(K_CNT, 3, "pre_flush_cnt");
    next();
    idle(); rd(4, 6);
    expect_v(K_CNT, 0, "flush_cnt");
    expect_v(K_RES0, 32'h11, "flush_write_kept");
    expect_v(K_BUSY0, 0, "flush_busy4");
    expect_v(K_BUSY1, 0, "flush_busy6");
    expect_v(K_STRAY, 0, "flush_no_stray");
    next();
    wr(6, 32'h66);
    expect_v(K_STRAY, 0, "stray_pre");
    next();
    idle();
    expect_v(K_STRAY, 1, "stray_pulse");
    expect_v(K_RES1, 32'h66, "stray_data_written");
    next();
    expect_v(K_STRAY, 0, "stray_one_cycle");
    next();

    // Mid-operation reset.
    rsv(1); next(); rsv(2); next(); rsv(7); next(); rsv(9); next(); rsv(11); next();
    idle();
    expect_v(K_CNT, 5, "five_busy");
    next();
    rst = 1'b1; wr(13, 32'hAB); rsv(12);
    next();
    idle(); rd(13, 5);
    expect_v(K_CNT, 0, "midrst_cnt");
    expect_v(K_STRAY, 0, "midrst_stray");
    expect_v(K_RES0, 0, "midrst_res13");
    expect_v(K_RES1, 0, "midrst_res5");
    next();
    rd(9, 12);
    expect_v(K_BUSY0, 0, "midrst_busy9");
    expect_v(K_BUSY1, 0, "midrst_busy12");
    expect_v(K_RES0, 0, "midrst_res9");
    next();
    next();

    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the core register file. Adds:
- clocked writes with a synchronous clear,
- N combinational read ports with same-cycle write bypass,
- a hardwired-zero register,
- a per-register busy scoreboard for the issue stage, with reserve, writeback-release, flush and an occupancy counter.

It sits between decode/issue (read and reserve) and writeback (write and release).

Parameters:
- XLEN, 32, data width.
- NREGS, 32, register count; power of two, at least 2. AW = $clog2(NREGS).
- NREAD, 2, number of read ports, 1..4.
- BYPASS, 1, when 1, a same-cycle write is forwarded to reads and masks busy.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- read_num, in, NREAD*AW, flattened read indices; port i is bits [i*AW +: AW].
- read_res, out, NREAD*XLEN, flattened read data.
- read_busy, out, NREAD, 1 means the register on port i holds no valid data yet.
- write_en, in, 1, writeback valid.
- write_num, in, AW, writeback index.
- write_res, in, XLEN, writeback data.
- rsv_en, in, 1, issue requests a reservation of rsv_num.
- rsv_num, in, AW, destination index to reserve.
- rsv_ok, out, 1, reservation granted this cycle (combinational).
- flush, in, 1, clears every busy bit.
- busy_cnt, out, AW+1, number of busy registers (registered).
- wb_stray, out, 1, registered one-cycle pulse: the previous cycle wrote back a register that was not busy.

Behaviour:
- Reset is synchronous and active-high. On a clk edge with rst=1:
  - all registers are set to 0,
  - all busy bits are cleared,
  - busy_cnt is set to 0 and wb_stray to 0.
  - rst has priority over every other input, so a reset mid-operation discards pending writes and reservations.
- Reads are combinational, zero latency.
  - read_res[i] = reg[read_num_i].
  - If BYPASS=1, write_en=1 and write_num == read_num_i, then read_res[i] = write_res.
  - With ZERO_REG=1, index 0 always reads 0, bypass included.
- Writes: when write_en=1, reg[write_num] is updated on the edge.
  - With ZERO_REG=1, a write to index 0 is dropped.
  - flush does not block a write.
- read_busy[i] = busy[read_num_i], except:
  - it is 0 when BYPASS=1 and a write to the same index is present this cycle;
  - it is 0 for index 0 when ZERO_REG=1.
- rsv_ok = rsv_en & ~flush & (busy[rsv_num]=0 OR (write_en AND write_num == rsv_num)).
  - Index 0 with ZERO_REG=1 is always granted and changes no state.
  - A denied request (write-after-write hazard) changes no state; issue stalls and retries.
- Busy update per edge, in priority order: rst, then flush (all cleared), then per register:
  - release by write_en at write_num clears the bit;
  - a granted reserve of rsv_num sets it;
  - reserve and release of the same register in the same cycle leaves the bit set (new owner).
- busy_cnt equals the next-state popcount of busy, updated incrementally:
  - +1 for a granted reserve of a previously non-busy register,
  - −1 for a release of a busy register not re-reserved,
  - net 0 for a simultaneous reserve and release of the same register.
  - It never exceeds NREGS−ZERO_REG and never underflows.
- wb_stray is registered high for one cycle after write_en=1 to a non-busy, non-zero register (and not flush). The data is still written.
- There is no other hidden state; the block holds no FSM beyond the busy vector and counter.

Decomposition:
- Shared package rf_pkg: default XLEN/NREGS, the AW function, and the index typedef.
- One sub-module: rf_scoreboard, holding the busy vector, rsv_ok, busy_cnt and wb_stray. The data array and read/bypass muxes stay in the top level.

Test Plan:
- Reset check: assert rst for 1 edge, then sweep read_num 0..31 on both ports. Every read_res is 0, read_busy is 0, busy_cnt is 0.
- Write and read: for each i in 1..31, write_num=i, write_res=i, one edge. Port 1 reads back i. A write to 0 of 0xDEADBEEF still reads 0.
- Bypass: reg5=7; in one cycle write_en=1, write_num=5, write_res=9 with read_num0=5. read_res0=9 in the same cycle; after the edge it still reads 9.
- Scoreboard hazard:
  - reserve 3: rsv_ok=1, busy_cnt=1, read_busy=1 for 3;
  - reserve 3 again: rsv_ok=0, busy_cnt stays 1;
  - writeback 3 together with reserve 3: rsv_ok=1, busy stays 1, busy_cnt stays 1;
  - writeback 3 alone: busy_cnt=0.
- Flush and stray:
  - reserve 4, 6 and 8 (busy_cnt=3), then flush while writing 4=0x11: busy_cnt=0 and reg4=0x11;
  - next, write 6: wb_stray=1 for exactly one cycle.
- Mid-operation reset: with 5 registers busy and write_en active, assert rst. Next cycle busy_cnt=0, all reads are 0, wb_stray=0.
